// File: rtl/mem_copy_engine_if.sv
// Command, status and memory-port bundle for mem_copy_engine.
// master = engine side; slave = command logic plus the source and destination memories.
interface mem_copy_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SRC_AW     = 32,
  parameter int DST_AW     = 26,
  parameter int LEN_W      = 32
);
  logic                  start;
  logic                  mode;
  logic [SRC_AW-1:0]     src_base;
  logic [DST_AW-1:0]     dst_base;
  logic [LEN_W-1:0]      length;
  logic                  busy;
  logic                  done;
  logic                  mismatch;
  logic [LEN_W-1:0]      err_index;
  logic                  src_rd_en;
  logic [SRC_AW-1:0]     src_addr;
  logic [DATA_WIDTH-1:0] src_rd_data;
  logic                  dst_rd_en;
  logic                  dst_wr_en;
  logic [DST_AW-1:0]     dst_addr;
  logic [DATA_WIDTH-1:0] dst_wr_data;
  logic [DATA_WIDTH-1:0] dst_rd_data;

  modport master (
    input  start, mode, src_base, dst_base, length, src_rd_data, dst_rd_data,
    output busy, done, mismatch, err_index,
    output src_rd_en, src_addr, dst_rd_en, dst_wr_en, dst_addr, dst_wr_data
  );

  modport slave (
    output start, mode, src_base, dst_base, length, src_rd_data, dst_rd_data,
    input  busy, done, mismatch, err_index,
    input  src_rd_en, src_addr, dst_rd_en, dst_wr_en, dst_addr, dst_wr_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Copies or compares word blocks between source and destination memories, two cycles per word.
// done pulses one cycle after the last word; no backpressure, read data is consumed one cycle after its strobe.
module mem_copy_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int SRC_AW     = 32,
  parameter int DST_AW     = 26,
  parameter int LEN_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_copy_engine_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_CHK,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [SRC_AW-1:0]     src_base_q, src_base_d;
  logic [DST_AW-1:0]     dst_base_q, dst_base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic                  mismatch_q, mismatch_d;
  logic [LEN_W-1:0]      err_index_q, err_index_d;

  logic [SRC_AW-1:0]     src_addr_cur;
  logic [DST_AW-1:0]     dst_addr_cur;
  logic                  last_word;

  logic                  busy;
  logic                  done;
  logic                  src_rd_en;
  logic [SRC_AW-1:0]     src_addr;
  logic                  dst_rd_en;
  logic                  dst_wr_en;
  logic [DST_AW-1:0]     dst_addr;
  logic [DATA_WIDTH-1:0] dst_wr_data;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mismatch_d  = mismatch_q;
    err_index_d = err_index_q;

    busy        = 1'b0;
    done        = 1'b0;
    src_rd_en   = 1'b0;
    src_addr    = '0;
    dst_rd_en   = 1'b0;
    dst_wr_en   = 1'b0;
    dst_addr    = '0;
    dst_wr_data = '0;

    // Addresses wrap silently at the memory width; the index is zero-extended or truncated to fit.
    src_addr_cur = src_base_q + SRC_AW'(idx_q);
    dst_addr_cur = dst_base_q + DST_AW'(idx_q);
    last_word    = (idx_q == len_q - LEN_W'(1));

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d      = bus.mode;
          src_base_d  = bus.src_base;
          dst_base_d  = bus.dst_base;
          len_d       = bus.length;
          idx_d       = '0;
          mismatch_d  = 1'b0;
          err_index_d = '0;
          state_d     = (bus.length == '0) ? S_FIN : S_RD;
        end
      end

      S_RD: begin
        busy      = 1'b1;
        src_rd_en = 1'b1;
        src_addr  = src_addr_cur;
        if (mode_q) begin
          dst_rd_en = 1'b1;
          dst_addr  = dst_addr_cur;
          state_d   = S_CHK;
        end else begin
          state_d   = S_WR;
        end
      end

      S_WR: begin
        busy        = 1'b1;
        dst_wr_en   = 1'b1;
        dst_addr    = dst_addr_cur;
        dst_wr_data = bus.src_rd_data;
        if (last_word) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_RD;
        end
      end

      S_CHK: begin
        busy = 1'b1;
        if (bus.src_rd_data != bus.dst_rd_data) begin
          mismatch_d  = 1'b1;
          err_index_d = idx_q;
          state_d     = S_FIN;
        end else if (last_word) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_RD;
        end
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reset cycle must not let a write or read strobe reach the memories.
    if (!rst_n) begin
      busy        = 1'b0;
      done        = 1'b0;
      src_rd_en   = 1'b0;
      src_addr    = '0;
      dst_rd_en   = 1'b0;
      dst_wr_en   = 1'b0;
      dst_addr    = '0;
      dst_wr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      mismatch_q  <= 1'b0;
      err_index_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_base_q  <= src_base_d;
      dst_base_q  <= dst_base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mismatch_q  <= mismatch_d;
      err_index_q <= err_index_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.mismatch    = mismatch_q;
  assign bus.err_index   = err_index_q;
  assign bus.src_rd_en   = src_rd_en;
  assign bus.src_addr    = src_addr;
  assign bus.dst_rd_en   = dst_rd_en;
  assign bus.dst_wr_en   = dst_wr_en;
  assign bus.dst_addr    = dst_addr;
  assign bus.dst_wr_data = dst_wr_data;

endmodule
